shared_mem_port: RTL and testbench

- Per-core shared-memory (URAM) access port with an MMIO-controlled lock handshake toward the row arbiter.
- Sits between a core's data-memory decoder and the row-level URAM arbiter/barrier logic.
- Replaces combinational grant gating with an explicit lock FSM, per-thread ownership, and a latency-aligned, thread-tagged read-return pipeline.
- Generalises widths, thread count and URAM read latency.

---
 rtl/shared_mem_port.sv | 186 ++++++++++++++++++
 tb/tb_shared_mem_port.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_port.sv
// rtl/shared_mem_port.sv - per-core shared-memory port with MMIO lock handshake and tagged read return
// Optional idle-lock watchdog: define SHMEM_LOCK_TIMEOUT_EN.
module shared_mem_port #(
  parameter int NUM_THREADS     = 16,
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int URAM_RD_LATENCY = 2,
  parameter int MMIO_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int TW = $clog2(NUM_THREADS),
  localparam int BE = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_mmio_en,
  input  logic [MMIO_ADDR_WIDTH-1:0] i_mmio_addr,
  input  logic                       i_mmio_wen,
  input  logic                       i_mmio_wdata,
  input  logic [TW-1:0]              i_mmio_thread,
  output logic                       o_mmio_rdata,
  input  logic                       i_shm_en,
  input  logic [ADDR_WIDTH-1:0]      i_shm_addr,
  input  logic [DATA_WIDTH-1:0]      i_shm_wdata,
  input  logic [BE-1:0]              i_shm_be,
  input  logic [TW-1:0]              i_shm_thread,
  output logic [DATA_WIDTH-1:0]      o_shm_rdata,
  output logic                       o_shm_rvalid,
  output logic [TW-1:0]              o_shm_rthread,
  output logic                       o_shm_err,
  output logic                       o_URAM_en,
  output logic [ADDR_WIDTH-1:0]      o_URAM_addr,
  output logic [DATA_WIDTH-1:0]      o_URAM_wr_data,
  output logic                       o_URAM_wr_en,
  input  logic [DATA_WIDTH-1:0]      i_URAM_rd_data,
  input  logic                       i_uram_emptied,
  output logic                       o_core_req,
  output logic                       o_core_locked,
  input  logic                       i_core_grant
);

  if (NUM_THREADS < 2 || URAM_RD_LATENCY < 1 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("shared_mem_port: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOCKED, S_RELEASE} state_t;

  localparam logic [MMIO_ADDR_WIDTH-1:0] A_LOCK   = MMIO_ADDR_WIDTH'(0);
  localparam logic [MMIO_ADDR_WIDTH-1:0] A_LOCKED = MMIO_ADDR_WIDTH'(1);
  localparam logic [MMIO_ADDR_WIDTH-1:0] A_EMPTY  = MMIO_ADDR_WIDTH'(2);
  localparam logic [MMIO_ADDR_WIDTH-1:0] A_OWNER  = MMIO_ADDR_WIDTH'(3);

  state_t                  state_q;
  logic [TW-1:0]           owner_q;
  logic                    req_q;
  logic                    locked_q;
  logic                    mmio_rdata_q;
  logic                    mmio_rdata_d;
  logic                    err_q;
  logic [URAM_RD_LATENCY-1:0] rv_q;
  logic [TW-1:0]           rt_q [URAM_RD_LATENCY];

  logic mmio_wr, mmio_rd, lock_wr, rel_wr, owner_locked;
  logic be_none, be_full, fwd, fwd_rd;

  assign mmio_wr      = i_mmio_en & i_mmio_wen;
  assign mmio_rd      = i_mmio_en & ~i_mmio_wen;
  assign owner_locked = (state_q == S_LOCKED) && (i_mmio_thread == owner_q);
  assign lock_wr      = mmio_wr && (i_mmio_addr == A_LOCK) && i_mmio_wdata && (state_q == S_IDLE);
  assign rel_wr       = mmio_wr && (i_mmio_addr == A_LOCK) && !i_mmio_wdata && owner_locked;

  assign be_none = ~|i_shm_be;
  assign be_full = &i_shm_be;
  assign fwd     = i_shm_en && (state_q == S_LOCKED) && (i_shm_thread == owner_q) && (be_none || be_full);
  assign fwd_rd  = fwd && be_none;

`ifdef SHMEM_LOCK_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [MMIO_ADDR_WIDTH-1:0] A_TMO = MMIO_ADDR_WIDTH'(4);
  logic [CW-1:0] to_cnt_q;
  logic          to_flag_q;
  logic          flag_rd;
  assign flag_rd = mmio_rd && (i_mmio_addr == A_TMO);
`endif

  // Lock FSM; req/locked are registered alongside each transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      req_q    <= 1'b0;
      locked_q <= 1'b0;
`ifdef SHMEM_LOCK_TIMEOUT_EN
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
`endif
    end else begin
`ifdef SHMEM_LOCK_TIMEOUT_EN
      if (flag_rd) to_flag_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: if (lock_wr) begin
          state_q <= S_REQ;
          owner_q <= i_mmio_thread;
          req_q   <= 1'b1;
        end
        S_REQ: if (i_core_grant) begin
          state_q  <= S_LOCKED;
          locked_q <= 1'b1;
`ifdef SHMEM_LOCK_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        S_LOCKED: begin
          if (rel_wr) begin
            state_q  <= S_RELEASE;
            req_q    <= 1'b0;
            locked_q <= 1'b0;
          end
`ifdef SHMEM_LOCK_TIMEOUT_EN
          else if (fwd) begin
            to_cnt_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            state_q   <= S_RELEASE;
            req_q     <= 1'b0;
            locked_q  <= 1'b0;
            to_flag_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        S_RELEASE: if (!i_core_grant) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mmio_rdata_d = 1'b0;
    if (mmio_rd) begin
      case (i_mmio_addr)
        A_LOCKED: mmio_rdata_d = locked_q;
        A_EMPTY:  mmio_rdata_d = i_uram_emptied;
        A_OWNER:  mmio_rdata_d = owner_locked;
`ifdef SHMEM_LOCK_TIMEOUT_EN
        A_TMO:    mmio_rdata_d = to_flag_q;
`endif
        default:  mmio_rdata_d = 1'b0;
      endcase
    end
  end

  // Read-return tag pipeline tracks URAM latency so data and thread line up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv_q         <= '0;
      err_q        <= 1'b0;
      mmio_rdata_q <= 1'b0;
      for (int i = 0; i < URAM_RD_LATENCY; i++) rt_q[i] <= '0;
    end else begin
      err_q        <= i_shm_en && !fwd;
      mmio_rdata_q <= mmio_rdata_d;
      rv_q[0]      <= fwd_rd;
      rt_q[0]      <= i_shm_thread;
      for (int i = 1; i < URAM_RD_LATENCY; i++) begin
        rv_q[i] <= rv_q[i-1];
        rt_q[i] <= rt_q[i-1];
      end
    end
  end

  assign o_mmio_rdata   = mmio_rdata_q;
  assign o_core_req     = req_q;
  assign o_core_locked  = locked_q;
  assign o_shm_err      = err_q;
  assign o_URAM_en      = fwd;
  assign o_URAM_wr_en   = fwd && be_full;
  assign o_URAM_addr    = fwd ? i_shm_addr : '0;
  assign o_URAM_wr_data = fwd ? i_shm_wdata : '0;
  assign o_shm_rvalid   = rv_q[URAM_RD_LATENCY-1];
  assign o_shm_rthread  = rv_q[URAM_RD_LATENCY-1] ? rt_q[URAM_RD_LATENCY-1] : '0;
  assign o_shm_rdata    = rv_q[URAM_RD_LATENCY-1] ? i_URAM_rd_data : '0;

endmodule

// File: tb/tb_shared_mem_port.sv
// tb/tb_shared_mem_port.sv - directed scoreboard bench for shared_mem_port
// Timeout section follows SHMEM_LOCK_TIMEOUT_EN.
module tb_shared_mem_port;
  localparam int L  = 2;
  localparam int TO = 16;

  logic        clk, reset;
  logic        mmio_en, mmio_wen, mmio_wdata, mmio_rdata;
  logic [3:0]  mmio_addr, mmio_thread;
  logic        shm_en, shm_rvalid, shm_err;
  logic [11:0] shm_addr;
  logic [31:0] shm_wdata, shm_rdata;
  logic [3:0]  shm_be, shm_thread, shm_rthread;
  logic        uram_en, uram_wr_en;
  logic [11:0] uram_addr;
  logic [31:0] uram_wr_data, uram_rd_data;
  logic        emptied, core_req, core_locked, grant;

  shared_mem_port #(.NUM_THREADS(16), .ADDR_WIDTH(12), .DATA_WIDTH(32),
                    .URAM_RD_LATENCY(L), .MMIO_ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .i_mmio_en(mmio_en), .i_mmio_addr(mmio_addr), .i_mmio_wen(mmio_wen),
    .i_mmio_wdata(mmio_wdata), .i_mmio_thread(mmio_thread), .o_mmio_rdata(mmio_rdata),
    .i_shm_en(shm_en), .i_shm_addr(shm_addr), .i_shm_wdata(shm_wdata), .i_shm_be(shm_be),
    .i_shm_thread(shm_thread), .o_shm_rdata(shm_rdata), .o_shm_rvalid(shm_rvalid),
    .o_shm_rthread(shm_rthread), .o_shm_err(shm_err),
    .o_URAM_en(uram_en), .o_URAM_addr(uram_addr), .o_URAM_wr_data(uram_wr_data),
    .o_URAM_wr_en(uram_wr_en), .i_URAM_rd_data(uram_rd_data),
    .i_uram_emptied(emptied), .o_core_req(core_req), .o_core_locked(core_locked),
    .i_core_grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int rv_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] thr; logic [31:0] data; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] ref_mem [0:4095];
  logic [31:0] uram_mem [0:4095];
  logic [31:0] rd_pipe [L];

  // URAM behavioural model driven from the DUT's URAM port.
  always @(posedge clk) begin
    rd_pipe[0] <= (uram_en && !uram_wr_en) ? uram_mem[uram_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (uram_en && uram_wr_en) uram_mem[uram_addr] <= uram_wr_data;
  end
  assign uram_rd_data = rd_pipe[L-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (reset && shm_rvalid) begin
      rv_count++;
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rthread", 64'(shm_rthread), 64'(mon_e.thr));
        check("rdata", 64'(shm_rdata), 64'(mon_e.data));
        check("rlatency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_wr(input logic [3:0] a, input logic v, input logic [3:0] thr);
    mmio_en = 1'b1; mmio_wen = 1'b1; mmio_addr = a; mmio_wdata = v; mmio_thread = thr;
    tick();
    mmio_en = 1'b0; mmio_wen = 1'b0;
  endtask

  task automatic mmio_rd(input logic [3:0] a, input logic [3:0] thr, input logic exp_v, input string tag);
    mmio_en = 1'b1; mmio_wen = 1'b0; mmio_addr = a; mmio_thread = thr;
    tick();
    check(tag, 64'(mmio_rdata), 64'(exp_v));
    mmio_en = 1'b0;
  endtask

  task automatic shm_drive(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic [3:0] thr, input bit push);
    shm_en = 1'b1; shm_addr = a; shm_wdata = d; shm_be = be; shm_thread = thr;
    if (push) sb.push_back('{thr, ref_mem[a], cyc + L});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i]  = 32'h1000_0000 + 32'(i * 7);
      uram_mem[i] = 32'h1000_0000 + 32'(i * 7);
    end
    ref_mem[12'h0A5]  = 32'hDEAD_BEEF;
    uram_mem[12'h0A5] = 32'hDEAD_BEEF;

    reset = 1'b0; grant = 1'b0; emptied = 1'b1;
    mmio_en = 1'b0; mmio_wen = 1'b0; mmio_addr = '0; mmio_wdata = 1'b0; mmio_thread = '0;
    shm_en = 1'b0; shm_addr = '0; shm_wdata = '0; shm_be = '0; shm_thread = '0;
    repeat (3) tick();
    check("rst_req", 64'(core_req), 64'd0);
    check("rst_locked", 64'(core_locked), 64'd0);
    check("rst_rvalid", 64'(shm_rvalid), 64'd0);
    check("rst_mmio_rdata", 64'(mmio_rdata), 64'd0);
    reset = 1'b1;
    tick();

    mmio_rd(4'd1, 4'd3, 1'b0, "idle_locked_rd");
    mmio_rd(4'd2, 4'd3, 1'b1, "emptied_rd");
    tick();
    check("mmio_rdata_idle", 64'(mmio_rdata), 64'd0);

    shm_drive(12'h0A5, 32'h0, 4'h0, 4'd3, 1'b0);
    #1 check("idle_drop_en", 64'(uram_en), 64'd0);
    tick(); shm_en = 1'b0;
    check("idle_drop_err", 64'(shm_err), 64'd1);

    check("req_before_lock", 64'(core_req), 64'd0);
    mmio_wr(4'd0, 1'b1, 4'd3);
    check("req_after_lock", 64'(core_req), 64'd1);
    check("locked_in_req", 64'(core_locked), 64'd0);
    grant = 1'b1;
    tick();
    check("locked_after_grant", 64'(core_locked), 64'd1);
    mmio_rd(4'd3, 4'd3, 1'b1, "owner_rd_t3");
    mmio_rd(4'd3, 4'd7, 1'b0, "owner_rd_t7");

    mmio_wr(4'd0, 1'b1, 4'd7);
    check("t7_lock_ignored", 64'(core_locked), 64'd1);
    mmio_wr(4'd0, 1'b0, 4'd7);
    check("t7_release_ignored", 64'(core_locked), 64'd1);
    mmio_rd(4'd3, 4'd3, 1'b1, "owner_kept");

    shm_drive(12'h0A5, 32'h0, 4'h0, 4'd3, 1'b1);
    #1 check("rd_uram_en", 64'(uram_en), 64'd1);
    check("rd_wr_en", 64'(uram_wr_en), 64'd0);
    check("rd_addr", 64'(uram_addr), 64'h0A5);
    tick(); shm_en = 1'b0;
    repeat (L + 1) tick();

    for (int i = 0; i < 4; i++) begin
      shm_drive(12'(12'h100 + i), 32'h0, 4'h0, 4'd3, 1'b1);
      tick();
    end
    shm_en = 1'b0;
    repeat (L + 1) tick();
    check("b2b_rvalid_count", 64'(rv_count), 64'd5);

    shm_drive(12'h010, 32'h1234_5678, 4'hF, 4'd5, 1'b0);
    #1 check("nonowner_en", 64'(uram_en), 64'd0);
    check("nonowner_addr", 64'(uram_addr), 64'd0);
    check("nonowner_wdata", 64'(uram_wr_data), 64'd0);
    tick(); shm_en = 1'b0;
    check("nonowner_err", 64'(shm_err), 64'd1);
    shm_drive(12'h010, 32'h1234_5678, 4'h3, 4'd3, 1'b0);
    #1 check("partial_en", 64'(uram_en), 64'd0);
    tick(); shm_en = 1'b0;
    check("partial_err", 64'(shm_err), 64'd1);
    shm_drive(12'h010, 32'hCAFE_F00D, 4'hF, 4'd3, 1'b0);
    ref_mem[12'h010] = 32'hCAFE_F00D;
    #1 check("wr_en", 64'(uram_en), 64'd1);
    check("wr_wr_en", 64'(uram_wr_en), 64'd1);
    check("wr_addr", 64'(uram_addr), 64'h010);
    check("wr_data", 64'(uram_wr_data), 64'hCAFE_F00D);
    tick(); shm_en = 1'b0;
    check("wr_no_err", 64'(shm_err), 64'd0);
    tick();
    check("err_one_cycle", 64'(shm_err), 64'd0);
    shm_drive(12'h010, 32'h0, 4'h0, 4'd3, 1'b1);
    tick(); shm_en = 1'b0;
    repeat (L + 1) tick();
    check("rdata_zero_idle", 64'(shm_rdata), 64'd0);

    shm_drive(12'h0A5, 32'h0, 4'h0, 4'd3, 1'b1);
    tick(); shm_en = 1'b0;
    mmio_wr(4'd0, 1'b0, 4'd3);
    check("release_req", 64'(core_req), 64'd0);
    check("release_locked", 64'(core_locked), 64'd0);
    mmio_rd(4'd1, 4'd3, 1'b0, "release_locked_rd");
    mmio_wr(4'd0, 1'b1, 4'd3);
    check("lock_in_release_ignored", 64'(core_req), 64'd0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    grant = 1'b0;
    tick();
    mmio_wr(4'd0, 1'b1, 4'd3);
    check("relock_req", 64'(core_req), 64'd1);
    grant = 1'b1;
    tick();
    check("relock_locked", 64'(core_locked), 64'd1);

    shm_drive(12'h0A5, 32'h0, 4'h0, 4'd3, 1'b0);
    tick(); shm_en = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_req", 64'(core_req), 64'd0);
    check("async_rst_locked", 64'(core_locked), 64'd0);
    check("async_rst_rvalid", 64'(shm_rvalid), 64'd0);
    begin
      int rv_before;
      rv_before = rv_count;
      tick(); tick();
      reset = 1'b1; grant = 1'b0;
      repeat (5) tick();
      check("no_rvalid_after_rst", 64'(rv_count), 64'(rv_before));
    end

    mmio_wr(4'd0, 1'b1, 4'd9);
    grant = 1'b1;
    tick();
    check("to_locked", 64'(core_locked), 64'd1);
`ifdef SHMEM_LOCK_TIMEOUT_EN
    repeat (TO - 1) tick();
    check("to_still_locked", 64'(core_locked), 64'd1);
    tick();
    check("to_released", 64'(core_locked), 64'd0);
    check("to_req_low", 64'(core_req), 64'd0);
    mmio_rd(4'd4, 4'd9, 1'b1, "to_flag_set");
    mmio_rd(4'd4, 4'd9, 1'b0, "to_flag_cleared");
`else
    repeat (TO + 4) tick();
    check("no_to_still_locked", 64'(core_locked), 64'd1);
    mmio_rd(4'd4, 4'd9, 1'b0, "no_to_addr4");
    mmio_rd(4'd3, 4'd9, 1'b1, "no_to_owner");
`endif
    mmio_rd(4'd9, 4'd9, 1'b0, "unmapped_addr");
    check("sb_final_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
